// File: rtl/red_seq_16bit.sv
// Multi-cycle WISC RED (byte-reduction) unit: sums the four operand bytes with one
// shared 8-bit adder over HI/LO steps and returns a sign-extended 10-bit total.
module red_seq_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] sum_out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_FIN,
    S_HOLD
  } state_e;

  state_e      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [8:0]  hi_q;
  logic [8:0]  lo_q;
  logic [15:0] sum_q;
  logic        out_valid_q;

  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic [8:0]  add_sum;
  logic [9:0]  total;

  // Shared byte adder: high bytes in HI, low bytes otherwise (result only used in LO).
  always_comb begin
    add_x   = a_q[7:0];
    add_y   = b_q[7:0];
    if (state_q == S_HI) begin
      add_x = a_q[15:8];
      add_y = b_q[15:8];
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y};
    total   = {1'b0, hi_q} + {1'b0, lo_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a_in;
            b_q     <= b_in;
            state_q <= S_HI;
          end
        end
        S_HI: begin
          hi_q    <= add_sum;
          state_q <= S_LO;
        end
        S_LO: begin
          lo_q    <= add_sum;
          state_q <= S_FIN;
        end
        S_FIN: begin
          sum_q       <= {{6{total[9]}}, total};
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign sum_out   = sum_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_red_seq_16bit.sv
// Directed bench for red_seq_16bit: timing, sign extension, backpressure,
// operand isolation, mid-operation reset and back-to-back issue.
module tb_red_seq_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum_out;
  logic        out_valid;
  logic        out_ready;

  int unsigned n_checks;
  int unsigned n_errors;

  red_seq_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with out_ready=1; operands switch to a2/b2 right after acceptance.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] a2, input logic [15:0] b2, input logic [15:0] exp);
    out_ready = 1'b1;
    a_in      = a;
    b_in      = b;
    in_valid  = 1'b1;
    check({tag, ".rdy_pre"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    a_in     = a2;
    b_in     = b2;
    check({tag, ".rdy_drop"}, {31'd0, in_ready}, 32'd0);
    check({tag, ".ov_k1"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({tag, ".ov_k2"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({tag, ".ov_k3"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({tag, ".ov"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".sum"}, {16'd0, sum_out}, {16'd0, exp});
    tick();
    check({tag, ".ov_done"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".rdy_done"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [15:0] bb_a [2];
  logic [15:0] bb_b [2];
  logic [15:0] bb_res [2];
  int unsigned bb_acc [2];
  int unsigned nacc;
  int unsigned nres;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    a_in      = '0;
    b_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    tick();
    check("rst.in_ready", {31'd0, in_ready}, 32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.sum_out", {16'd0, sum_out}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    run_op("basic", 16'h22BB, 16'h22BB, 16'h22BB, 16'h22BB, 16'h01BA);
    run_op("ffff",  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFC);
    run_op("8080",  16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'hFE00);
    run_op("zero",  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Backpressure: first result held while a second request waits with in_valid high.
    out_ready = 1'b0;
    a_in      = 16'h0102;
    b_in      = 16'h0304;
    in_valid  = 1'b1;
    tick();
    a_in = 16'h0505;
    b_in = 16'h0101;
    tick();
    tick();
    tick();
    check("bp.ov", {31'd0, out_valid}, 32'd1);
    check("bp.sum", {16'd0, sum_out}, 32'h000A);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp.hold_ov", {31'd0, out_valid}, 32'd1);
      check("bp.hold_sum", {16'd0, sum_out}, 32'h000A);
      check("bp.hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp.consumed_ov", {31'd0, out_valid}, 32'd0);
    check("bp.consumed_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp.second_acc", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    check("bp.second_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("bp.second_ov", {31'd0, out_valid}, 32'd1);
    check("bp.second_sum", {16'd0, sum_out}, 32'h000C);
    tick();
    check("bp.second_done", {31'd0, out_valid}, 32'd0);

    run_op("iso", 16'h22BB, 16'h22BB, 16'hFFFF, 16'hFFFF, 16'h01BA);

    // Reset while the operation sits in LO.
    a_in     = 16'hFFFF;
    b_in     = 16'hFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst.ov", {31'd0, out_valid}, 32'd0);
    check("mid_rst.sum", {16'd0, sum_out}, 32'd0);
    check("mid_rst.rdy_in_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst.rdy", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst.no_result", {31'd0, out_valid}, 32'd0);
    end
    run_op("after_rst", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFC);

    // Back-to-back with in_valid held and out_ready=1.
    bb_a[0] = 16'h1111; bb_b[0] = 16'h2222;
    bb_a[1] = 16'h7F7F; bb_b[1] = 16'h0101;
    nacc = 0;
    nres = 0;
    out_ready = 1'b1;
    for (int unsigned cyc = 0; cyc < 30 && nres < 2; cyc++) begin
      in_valid = (nacc < 2);
      if (nacc < 2) begin
        a_in = bb_a[nacc];
        b_in = bb_b[nacc];
      end
      #0;
      if (out_valid && out_ready) begin
        bb_res[nres] = sum_out;
        nres++;
      end
      if (in_ready && in_valid) begin
        bb_acc[nacc] = cyc;
        nacc++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("b2b.n_acc", nacc, 32'd2);
    check("b2b.n_res", nres, 32'd2);
    if (nacc == 2) check("b2b.spacing", bb_acc[1] - bb_acc[0], 32'd5);
    if (nres == 2) begin
      check("b2b.res0", {16'd0, bb_res[0]}, 32'h0066);
      check("b2b.res1", {16'd0, bb_res[1]}, 32'h0100);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
